// File: rtl/chess_pkg.sv
// Shared types and constants for the move sequencer and its step decoder.
package chess_pkg;

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
  } square_t;

  // Numbered to match the bit positions of the evaluator allow mask.
  typedef enum logic [2:0] {
    DIR_UPLEFT    = 3'd0,
    DIR_LEFT      = 3'd1,
    DIR_DOWNLEFT  = 3'd2,
    DIR_DOWN      = 3'd3,
    DIR_RIGHTDOWN = 3'd4,
    DIR_RIGHT     = 3'd5,
    DIR_UPRIGHT   = 3'd6,
    DIR_UP        = 3'd7
  } dir_e;

  typedef enum logic [2:0] {
    RC_OK         = 3'd0,
    RC_EMPTY_SRC  = 3'd1,
    RC_WRONG_TURN = 3'd2,
    RC_BAD_DELTA  = 3'd3,
    RC_OWN_PIECE  = 3'd4,
    RC_BLOCKED    = 3'd5
  } rsp_code_e;

  localparam int unsigned OCC_BIT   = 0;
  localparam int unsigned COLOR_BIT = 1;
  localparam int unsigned KING_BIT  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_EVAL,
    ST_DECIDE,
    ST_RESP,
    ST_SCAN
  } state_e;

endpackage

// File: rtl/step_dir_decode.sv
// Maps a from/to square pair onto one of the eight unit-step directions.
module step_dir_decode
  import chess_pkg::*;
(
  input  square_t     from_sq,
  input  square_t     to_sq,
  output dir_e        dir,
  output logic        step_ok
);

  logic [3:0] d_row;
  logic [3:0] d_col;

  // Zero-extended 4-bit differences span -7..+7, so edge squares cannot alias a unit step.
  always_comb begin
    d_row   = {1'b0, to_sq.row} - {1'b0, from_sq.row};
    d_col   = {1'b0, to_sq.col} - {1'b0, from_sq.col};
    dir     = DIR_UP;
    step_ok = 1'b1;
    case ({d_row, d_col})
      {4'hF, 4'h0}: dir = DIR_UP;
      {4'hF, 4'h1}: dir = DIR_UPRIGHT;
      {4'h0, 4'h1}: dir = DIR_RIGHT;
      {4'h1, 4'h1}: dir = DIR_RIGHTDOWN;
      {4'h1, 4'h0}: dir = DIR_DOWN;
      {4'h1, 4'hF}: dir = DIR_DOWNLEFT;
      {4'h0, 4'hF}: dir = DIR_LEFT;
      {4'hF, 4'hF}: dir = DIR_UPLEFT;
      default:      step_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/move_sequencer.sv
// Sequences single-step move requests against a shared move evaluator.
// Optional post-move no-legal-step scan is enabled with `define MOVE_SCAN_EN.
module move_sequencer
  import chess_pkg::*;
#(
  parameter int unsigned MOVE_CNT_W = 10,
  parameter bit          FIRST_TURN = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            from_row,
  input  logic [2:0]            from_column,
  input  logic [2:0]            to_row,
  input  logic [2:0]            to_column,
  input  logic [7:0][7:0][2:0]  boardPos,
  output logic [2:0]            eval_row,
  output logic [2:0]            eval_column,
  output logic                  eval_color,
  input  logic [7:0]            eval_allow,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_legal,
  output logic [2:0]            rsp_code,
  output logic                  turn,
  output logic [MOVE_CNT_W-1:0] move_count
`ifdef MOVE_SCAN_EN
  ,
  output logic                  no_moves
`endif
);

  state_e    state;
  square_t   src;
  square_t   dst;
  dir_e      dir;
  logic      step_ok;
  logic [2:0] src_cell;
  logic [2:0] dst_cell;
  logic      check_fail;
  rsp_code_e check_code;
  logic      unused_king;

  step_dir_decode u_step_dir_decode (
    .from_sq (src),
    .to_sq   (dst),
    .dir     (dir),
    .step_ok (step_ok)
  );

  assign src_cell = boardPos[src.row][src.col];
  assign dst_cell = boardPos[dst.row][dst.col];

  always_comb begin
    check_fail = 1'b1;
    check_code = RC_OK;
    if (!src_cell[OCC_BIT])                                  check_code = RC_EMPTY_SRC;
    else if (src_cell[COLOR_BIT] != turn)                    check_code = RC_WRONG_TURN;
    else if (!step_ok)                                       check_code = RC_BAD_DELTA;
    else if (dst_cell[OCC_BIT] && dst_cell[COLOR_BIT] == turn) check_code = RC_OWN_PIECE;
    else                                                     check_fail = 1'b0;
  end

  always_comb begin
    unused_king = 1'b0;
    for (int unsigned r = 0; r < 8; r++)
      for (int unsigned c = 0; c < 8; c++)
        unused_king = unused_king ^ boardPos[r][c][KING_BIT];
  end

`ifdef MOVE_SCAN_EN
  logic [5:0] scan_idx;
  logic       scan_phase;
  logic       scan_any;
  logic [2:0] scan_cell;
  logic       scan_hit;

  assign scan_cell = boardPos[scan_idx[5:3]][scan_idx[2:0]];
  assign scan_hit  = scan_cell[OCC_BIT] && (scan_cell[COLOR_BIT] == turn) && (|eval_allow);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_legal   <= 1'b0;
      rsp_code    <= '0;
      eval_row    <= '0;
      eval_column <= '0;
      eval_color  <= 1'b0;
      turn        <= FIRST_TURN;
      move_count  <= '0;
      src         <= '0;
      dst         <= '0;
`ifdef MOVE_SCAN_EN
      no_moves    <= 1'b0;
      scan_idx    <= '0;
      scan_phase  <= 1'b0;
      scan_any    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            src.row   <= from_row;
            src.col   <= from_column;
            dst.row   <= to_row;
            dst.col   <= to_column;
            req_ready <= 1'b0;
            state     <= ST_CHECK;
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_CHECK: begin
          if (check_fail) begin
            rsp_valid <= 1'b1;
            rsp_legal <= 1'b0;
            rsp_code  <= check_code;
            state     <= ST_RESP;
          end else begin
            eval_row    <= src.row;
            eval_column <= src.col;
            eval_color  <= turn;
            state       <= ST_EVAL;
          end
        end
        ST_EVAL: state <= ST_DECIDE;
        ST_DECIDE: begin
          rsp_valid <= 1'b1;
          rsp_legal <= eval_allow[dir];
          rsp_code  <= eval_allow[dir] ? RC_OK : RC_BLOCKED;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (rsp_legal) begin
              turn <= ~turn;
              if (move_count != '1)
                move_count <= move_count + MOVE_CNT_W'(1);
            end
`ifdef MOVE_SCAN_EN
            if (rsp_legal) begin
              scan_idx   <= '0;
              scan_phase <= 1'b0;
              scan_any   <= 1'b0;
              state      <= ST_SCAN;
            end else begin
              req_ready <= 1'b1;
              state     <= ST_IDLE;
            end
`else
            req_ready <= 1'b1;
            state     <= ST_IDLE;
`endif
          end
        end
`ifdef MOVE_SCAN_EN
        // Phase 0 presents a square to the evaluator, phase 1 samples its mask.
        ST_SCAN: begin
          if (!scan_phase) begin
            eval_row    <= scan_idx[5:3];
            eval_column <= scan_idx[2:0];
            eval_color  <= turn;
            scan_phase  <= 1'b1;
          end else begin
            scan_phase <= 1'b0;
            scan_idx   <= scan_idx + 6'd1;
            if (scan_idx == 6'd63) begin
              no_moves  <= !(scan_any | scan_hit);
              req_ready <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              scan_any <= scan_any | scan_hit;
            end
          end
        end
`endif
        default: begin
          req_ready <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
